// File: rtl/alarm_pkg.sv
// alarm_pkg: shared types and constants for the alarm hub.
//   ch_state_e  per-channel FSM state
//   CH_*        channel index assignments (lower index = higher priority)
//   id_width()  width of an index into n channels (at least 1 bit)
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PEND,
    ST_ALARM,
    ST_ACKED
  } ch_state_e;

  localparam int unsigned CH_FIRE    = 0;
  localparam int unsigned CH_BURGLAR = 1;
  localparam int unsigned CH_RAIN    = 2;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alarm_hub_if.sv
// alarm_hub_if: sensor-side inputs and display/actuator-side outputs of alarm_hub.
//   master: drives sensor/arm/ack, observes alarm/escalate/any_alarm/active_id/siren
//   slave : the hub itself
interface alarm_hub_if
  import alarm_pkg::*;
#(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned IDW    = id_width(NUM_CH)
);
  logic [NUM_CH-1:0] sensor;
  logic [NUM_CH-1:0] arm;
  logic [NUM_CH-1:0] ack;
  logic [NUM_CH-1:0] alarm;
  logic [NUM_CH-1:0] escalate;
  logic              any_alarm;
  logic [IDW-1:0]    active_id;
  logic              siren;

  modport master (
    output sensor, arm, ack,
    input  alarm, escalate, any_alarm, active_id, siren
  );

  modport slave (
    input  sensor, arm, ack,
    output alarm, escalate, any_alarm, active_id, siren
  );
endinterface

// File: rtl/alarm_channel.sv
// alarm_channel: one latching alarm channel.
//   clk, reset  : clock, synchronous active-high reset
//   sensor, arm : raw sensor level and channel enable
//   ack         : acknowledge, honoured only while the alarm is latched
//   alarm       : registered alarm latch
//   alarm_nxt   : value alarm takes at the next edge (lets the hub register
//                 the siren on the same edge the alarm rises)
//   escalate    : sticky "unacknowledged for ESCALATE cycles" flag
module alarm_channel
  import alarm_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned ESCALATE = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor,
  input  logic arm,
  input  logic ack,
  output logic alarm,
  output logic alarm_nxt,
  output logic escalate
);

  localparam int unsigned DBW = $clog2(DEBOUNCE + 1);
  localparam int unsigned ESW = $clog2(ESCALATE + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE - 1);
  localparam logic [ESW-1:0] ES_MAX  = ESW'(ESCALATE);
  localparam logic [ESW-1:0] ES_LAST = ESW'(ESCALATE - 1);

  ch_state_e      state_q, state_d;
  logic [DBW-1:0] cnt_q, cnt_d;
  logic [ESW-1:0] tmr_q, tmr_d;
  logic           esc_q, esc_d;
  logic           trig;

  assign trig = sensor & arm;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    esc_d   = esc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (trig) begin
          if (DEBOUNCE == 1) begin
            state_d = ST_ALARM;
            tmr_d   = '0;
            esc_d   = 1'b0;
          end else begin
            state_d = ST_PEND;
            cnt_d   = DBW'(1);
          end
        end
      end
      ST_PEND: begin
        if (!trig) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= DB_LAST) begin
          // this sample is the DEBOUNCE-th consecutive high one
          state_d = ST_ALARM;
          cnt_d   = '0;
          tmr_d   = '0;
          esc_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + DBW'(1);
        end
      end
      ST_ALARM: begin
        if (ack) begin
          state_d = ST_ACKED;
          tmr_d   = '0;
          esc_d   = 1'b0;
        end else begin
          if (tmr_q != ES_MAX) tmr_d = tmr_q + ESW'(1);
          if (tmr_q >= ES_LAST) esc_d = 1'b1;
        end
      end
      ST_ACKED: begin
        if (!trig) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tmr_q   <= '0;
      esc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      esc_q   <= esc_d;
    end
  end

  assign alarm     = (state_q == ST_ALARM);
  assign alarm_nxt = (state_d == ST_ALARM);
  assign escalate  = esc_q;

endmodule

// File: rtl/alarm_hub.sv
// alarm_hub: NUM_CH latching alarm channels, priority encoder and pulsed siren.
//   clk, reset : clock, synchronous active-high reset
//   bus        : alarm_hub_if.slave (sensor/arm/ack in; alarm/escalate/
//                any_alarm/active_id/siren out)
module alarm_hub
  import alarm_pkg::*;
#(
  parameter int unsigned NUM_CH     = 3,
  parameter int unsigned DEBOUNCE   = 4,
  parameter int unsigned ESCALATE   = 16,
  parameter int unsigned SIREN_HALF = 2
) (
  input  logic        clk,
  input  logic        reset,
  alarm_hub_if.slave  bus
);

  localparam int unsigned IDW = id_width(NUM_CH);
  localparam int unsigned SHW = $clog2(SIREN_HALF + 1);
  localparam logic [SHW-1:0] SH_MAX = SHW'(SIREN_HALF);

  logic [NUM_CH-1:0] alarm_vec;
  logic [NUM_CH-1:0] alarm_nxt;
  logic [NUM_CH-1:0] esc_vec;
  logic [IDW-1:0]    id;
  logic              any_nxt;
  logic [SHW-1:0]    ph_q, ph_d;
  logic              siren_q, siren_d;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    alarm_channel #(
      .DEBOUNCE (DEBOUNCE),
      .ESCALATE (ESCALATE)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .sensor    (bus.sensor[g]),
      .arm       (bus.arm[g]),
      .ack       (bus.ack[g]),
      .alarm     (alarm_vec[g]),
      .alarm_nxt (alarm_nxt[g]),
      .escalate  (esc_vec[g])
    );
  end

  // Scan from highest index down so the lowest set channel is written last.
  always_comb begin
    id = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (alarm_vec[NUM_CH-1-i]) id = IDW'(NUM_CH - 1 - i);
    end
  end

  // Siren follows the next-cycle alarm vector so it rises on the same edge
  // as the first alarm. ph_q==0 marks "no episode in progress".
  assign any_nxt = |alarm_nxt;

  always_comb begin
    ph_d    = ph_q;
    siren_d = siren_q;
    if (!any_nxt) begin
      ph_d    = '0;
      siren_d = 1'b0;
    end else if (ph_q == '0) begin
      ph_d    = SHW'(1);
      siren_d = 1'b1;
    end else if (ph_q >= SH_MAX) begin
      ph_d    = SHW'(1);
      siren_d = !siren_q;
    end else begin
      ph_d = ph_q + SHW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ph_q    <= '0;
      siren_q <= 1'b0;
    end else begin
      ph_q    <= ph_d;
      siren_q <= siren_d;
    end
  end

  assign bus.alarm     = alarm_vec;
  assign bus.escalate  = esc_vec;
  assign bus.any_alarm = |alarm_vec;
  assign bus.active_id = id;
  assign bus.siren     = siren_q;

endmodule

// File: tb/tb_alarm_hub.sv
// tb_alarm_hub: table-driven vectors, hand sequences for multi-cycle corners,
// and random stimulus checked against a behavioural model of alarm_hub.
module tb_alarm_hub;
  import alarm_pkg::*;

  localparam int unsigned NCH  = 3;
  localparam int unsigned DEB  = 4;
  localparam int unsigned ESC  = 16;
  localparam int unsigned HALF = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alarm_hub_if #(.NUM_CH(NCH)) bus ();

  alarm_hub #(
    .NUM_CH     (NCH),
    .DEBOUNCE   (DEB),
    .ESCALATE   (ESC),
    .SIREN_HALF (HALF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  // run: consecutive armed-high samples; lat: alarm latched;
  // blk: acknowledged, waiting for the condition to clear; age: unacked edges.
  int run [NCH];
  bit lat [NCH];
  bit blk [NCH];
  bit mesc[NCH];
  int age [NCH];
  int ep;        // edges since the current alarm episode began
  bit prev_any;

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      run[i] = 0; lat[i] = 0; blk[i] = 0; mesc[i] = 0; age[i] = 0;
    end
    ep = 0;
    prev_any = 0;
  endfunction

  function automatic void model_step(input logic [NCH-1:0] s, a, k, input logic r);
    bit any;
    if (r) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NCH; i++) begin
      bit hit;
      hit = s[i] & a[i];
      if (lat[i]) begin
        if (k[i]) begin
          lat[i] = 0; blk[i] = 1; mesc[i] = 0; age[i] = 0;
        end else begin
          if (age[i] < ESC) age[i]++;
          if (age[i] >= ESC) mesc[i] = 1;
        end
      end else if (blk[i]) begin
        if (!hit) blk[i] = 0;
      end else if (hit) begin
        run[i]++;
        if (run[i] >= DEB) begin
          lat[i] = 1; run[i] = 0; age[i] = 0;
        end
      end else begin
        run[i] = 0;
      end
    end
    any = 0;
    for (int i = 0; i < NCH; i++) any |= lat[i];
    ep = any ? (prev_any ? ep + 1 : 0) : 0;
    prev_any = any;
  endfunction

  function automatic logic [NCH-1:0] m_alarm();
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[i] = lat[i];
    return v;
  endfunction

  function automatic logic [NCH-1:0] m_esc();
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[i] = mesc[i];
    return v;
  endfunction

  function automatic int m_id();
    for (int i = 0; i < NCH; i++) if (lat[i]) return i;
    return 0;
  endfunction

  function automatic logic m_siren();
    return prev_any && (((ep / HALF) % 2) == 0);
  endfunction

  // Drive one cycle, sample 1 time unit after the edge, compare with model.
  task automatic step(input logic [NCH-1:0] s, a, k, input logic r);
    bus.sensor = s;
    bus.arm    = a;
    bus.ack    = k;
    reset      = r;
    @(posedge clk);
    #1;
    model_step(s, a, k, r);
    chk("model_alarm",     32'(bus.alarm),     32'(m_alarm()));
    chk("model_escalate",  32'(bus.escalate),  32'(m_esc()));
    chk("model_any_alarm", 32'(bus.any_alarm), 32'(prev_any));
    chk("model_active_id", 32'(bus.active_id), 32'(m_id()));
    chk("model_siren",     32'(bus.siren),     32'(m_siren()));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0] s, a, k;
    logic       r;
    logic [2:0] alarm, esc;
    logic       any;
    logic [1:0] id;
    logic       siren;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [2:0] s, a, k, input logic r,
                              input logic [2:0] al, es, input logic an,
                              input logic [1:0] id, input logic sr);
    vec_t v;
    v.s = s; v.a = a; v.k = k; v.r = r;
    v.alarm = al; v.esc = es; v.any = an; v.id = id; v.siren = sr;
    return v;
  endfunction

  task automatic expect_out(input string tag, input logic [2:0] al, es,
                            input logic an, input logic [1:0] id, input logic sr);
    chk({tag, "_alarm"},     32'(bus.alarm),     32'(al));
    chk({tag, "_escalate"},  32'(bus.escalate),  32'(es));
    chk({tag, "_any_alarm"}, 32'(bus.any_alarm), 32'(an));
    chk({tag, "_active_id"}, 32'(bus.active_id), 32'(id));
    chk({tag, "_siren"},     32'(bus.siren),     32'(sr));
  endtask

  initial begin
    logic [NCH-1:0] rs, ra, rk;
    logic rr;

    bus.sensor = '0;
    bus.arm    = '0;
    bus.ack    = '0;
    model_reset();

    //           s       a       k       r  alarm   esc     any id  siren
    tbl.push_back(mk(3'b000, 3'b000, 3'b000, 1, 3'b000, 3'b000, 0, 0, 0));
    tbl.push_back(mk(3'b001, 3'b111, 3'b000, 0, 3'b000, 3'b000, 0, 0, 0));
    tbl.push_back(mk(3'b001, 3'b111, 3'b000, 0, 3'b000, 3'b000, 0, 0, 0));
    tbl.push_back(mk(3'b001, 3'b111, 3'b000, 0, 3'b000, 3'b000, 0, 0, 0));
    tbl.push_back(mk(3'b001, 3'b111, 3'b000, 0, 3'b001, 3'b000, 1, 0, 1));
    tbl.push_back(mk(3'b001, 3'b111, 3'b000, 0, 3'b001, 3'b000, 1, 0, 1));
    tbl.push_back(mk(3'b001, 3'b111, 3'b000, 0, 3'b001, 3'b000, 1, 0, 0));
    tbl.push_back(mk(3'b001, 3'b111, 3'b000, 0, 3'b001, 3'b000, 1, 0, 0));
    tbl.push_back(mk(3'b001, 3'b111, 3'b000, 0, 3'b001, 3'b000, 1, 0, 1));
    tbl.push_back(mk(3'b001, 3'b111, 3'b001, 0, 3'b000, 3'b000, 0, 0, 0));
    tbl.push_back(mk(3'b001, 3'b111, 3'b000, 0, 3'b000, 3'b000, 0, 0, 0));
    tbl.push_back(mk(3'b000, 3'b111, 3'b000, 0, 3'b000, 3'b000, 0, 0, 0));
    tbl.push_back(mk(3'b010, 3'b111, 3'b000, 0, 3'b000, 3'b000, 0, 0, 0));
    tbl.push_back(mk(3'b010, 3'b111, 3'b000, 0, 3'b000, 3'b000, 0, 0, 0));
    tbl.push_back(mk(3'b010, 3'b111, 3'b000, 0, 3'b000, 3'b000, 0, 0, 0));
    tbl.push_back(mk(3'b000, 3'b111, 3'b000, 0, 3'b000, 3'b000, 0, 0, 0));
    tbl.push_back(mk(3'b010, 3'b111, 3'b000, 0, 3'b000, 3'b000, 0, 0, 0));
    tbl.push_back(mk(3'b010, 3'b111, 3'b000, 0, 3'b000, 3'b000, 0, 0, 0));
    tbl.push_back(mk(3'b010, 3'b111, 3'b000, 0, 3'b000, 3'b000, 0, 0, 0));
    tbl.push_back(mk(3'b010, 3'b111, 3'b000, 0, 3'b010, 3'b000, 1, 1, 1));
    tbl.push_back(mk(3'b100, 3'b011, 3'b000, 0, 3'b010, 3'b000, 1, 1, 1));
    tbl.push_back(mk(3'b100, 3'b011, 3'b000, 0, 3'b010, 3'b000, 1, 1, 0));
    tbl.push_back(mk(3'b000, 3'b111, 3'b010, 0, 3'b000, 3'b000, 0, 0, 0));

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].s, tbl[i].a, tbl[i].k, tbl[i].r);
      expect_out($sformatf("tbl%0d", i), tbl[i].alarm, tbl[i].esc,
                 tbl[i].any, tbl[i].id, tbl[i].siren);
    end

    // Escalation, then ack while the sensor is still high.
    step('0, '0, '0, 1);
    repeat (DEB) step(3'b001, 3'b111, 3'b000, 0);
    expect_out("esc_rise", 3'b001, 3'b000, 1, 0, 1);
    repeat (ESC - 1) step(3'b001, 3'b111, 3'b000, 0);
    chk("esc_before", 32'(bus.escalate), 32'(3'b000));
    step(3'b001, 3'b111, 3'b000, 0);
    chk("esc_set", 32'(bus.escalate), 32'(3'b001));
    step(3'b001, 3'b111, 3'b001, 0);
    expect_out("esc_ack", 3'b000, 3'b000, 0, 0, 0);
    repeat (5) step(3'b001, 3'b111, 3'b000, 0);
    chk("acked_hold", 32'(bus.alarm), 32'(3'b000));
    step(3'b000, 3'b111, 3'b000, 0);
    repeat (DEB - 1) step(3'b001, 3'b111, 3'b000, 0);
    chk("rearm_pend", 32'(bus.alarm), 32'(3'b000));
    step(3'b001, 3'b111, 3'b000, 0);
    chk("rearm_alarm", 32'(bus.alarm), 32'(3'b001));

    // Priority: rain then burglar, acknowledged in turn.
    step('0, '0, '0, 1);
    repeat (DEB) step(3'b100, 3'b111, 3'b000, 0);
    expect_out("prio_rain", 3'b100, 3'b000, 1, 2'(CH_RAIN), 1);
    repeat (DEB) step(3'b110, 3'b111, 3'b000, 0);
    chk("prio_two_alarm", 32'(bus.alarm), 32'(3'b110));
    chk("prio_two_id", 32'(bus.active_id), 32'(CH_BURGLAR));
    step(3'b000, 3'b111, 3'b010, 0);
    chk("prio_ack1_alarm", 32'(bus.alarm), 32'(3'b100));
    chk("prio_ack1_id", 32'(bus.active_id), 32'(CH_RAIN));
    step(3'b000, 3'b111, 3'b100, 0);
    expect_out("prio_ack2", 3'b000, 3'b000, 0, 0, 0);

    // Disarm while latched; disarmed channel never raises.
    step('0, '0, '0, 1);
    repeat (DEB) step(3'b001, 3'b111, 3'b000, 0);
    step(3'b001, 3'b110, 3'b000, 0);
    step(3'b000, 3'b110, 3'b000, 0);
    chk("disarm_latched", 32'(bus.alarm), 32'(3'b001));
    repeat (6) step(3'b100, 3'b011, 3'b000, 0);
    chk("disarmed_rain", 32'(bus.alarm), 32'(3'b001));

    // Reset in the middle of two escalated alarms.
    step('0, '0, '0, 1);
    repeat (DEB + ESC) step(3'b011, 3'b111, 3'b000, 0);
    chk("mid_esc", 32'(bus.escalate), 32'(3'b011));
    step(3'b011, 3'b111, 3'b000, 1);
    expect_out("mid_reset", 3'b000, 3'b000, 0, 0, 0);
    repeat (DEB - 1) step(3'b011, 3'b111, 3'b000, 0);
    chk("post_reset_pend", 32'(bus.alarm), 32'(3'b000));
    step(3'b011, 3'b111, 3'b000, 0);
    chk("post_reset_alarm", 32'(bus.alarm), 32'(3'b011));

    // Random stimulus against the model.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NCH; i++) begin
        rs[i] = ($urandom_range(3) != 0);
        ra[i] = ($urandom_range(7) != 0);
        rk[i] = ((n % 128) < 64) ? ($urandom_range(39) == 0) : ($urandom_range(3) == 0);
      end
      rr = ($urandom_range(299) == 0);
      step(rs, ra, rk, rr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alarm_hub.md
# alarm_hub

Parametrised, latching alarm controller for the smart-home core: NUM_CH independent alarm channels (default 3, index 0 fire, 1 burglar, 2 rain). Each channel has an arm mask, a debounce filter, a sticky alarm latch cleared only by acknowledge, and an escalation timer. A fixed-priority encoder reports the most urgent active channel and drives a pulsed siren. It sits between the raw sensor inputs and the home display/actuator logic.

## Interface
- NUM_CH, 3, number of alarm channels (1..16); lower index means higher priority
- DEBOUNCE, 4, consecutive high samples required to raise an alarm (>=1)
- ESCALATE, 16, cycles an alarm may stay unacknowledged before its escalate bit sets (>=1)
- SIREN_HALF, 2, siren half-period in cycles (>=1)
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- sensor  in  NUM_CH  raw per-channel sensor levels
- arm  in  NUM_CH  per-channel enable; disarmed channels never raise new alarms
- ack  in  NUM_CH  per-channel acknowledge, level-sampled each cycle
- alarm  out  NUM_CH  latched alarm per channel
- escalate  out  NUM_CH  sticky per-channel "unacknowledged too long" flag
- any_alarm  out  1  OR of alarm
- active_id  out  IDW=max(1,$clog2(NUM_CH))  index of lowest-numbered channel with alarm set; 0 when none
- siren  out  1  square wave while any_alarm, else 0

## Operation
- Per-channel FSM states: IDLE, PEND, ALARM, ACKED.
- IDLE: if arm&sensor sampled high -> PEND with debounce count 1 (if DEBOUNCE==1 go straight to ALARM).
- PEND: sensor low or arm low -> IDLE, count cleared; count reaches DEBOUNCE -> ALARM; else count+1.
- ALARM: alarm=1; sensor and arm ignored (latched). ack -> ACKED, alarm=0, escalate=0, escalation timer cleared. Otherwise timer+1 (saturating); timer reaching ESCALATE sets escalate.
- ACKED: alarm=0; stays until sensor low or arm low, then IDLE. Prevents re-trigger while the condition persists.
- ack in IDLE/PEND/ACKED ignored. ack takes precedence over escalation in the same cycle.
- Channels fully independent; all may be in ALARM at once.
- active_id: combinational priority encode of registered alarm vector. any_alarm likewise.
- siren: phase counter runs only while any_alarm; siren starts 1 on the first cycle any_alarm is high, toggles every SIREN_HALF cycles; counter and siren forced 0 when any_alarm low, so each new alarm episode restarts the phase.
- Counters: debounce width $clog2(DEBOUNCE+1), escalation $clog2(ESCALATE+1) saturating, siren $clog2(SIREN_HALF+1).

## Timing
- Reset: all FSMs IDLE, all counters 0; alarm, escalate, any_alarm, active_id, siren all 0 on the cycle after reset is sampled. Reset mid-alarm clears everything in that edge.
- Sensor high from edge k (armed): alarm visible after edge k+DEBOUNCE-1 (DEBOUNCE=4: 4th sampled-high edge).
- Single low sample in PEND restarts debounce.
- escalate visible ESCALATE cycles after alarm rose, if no ack.
- ack sampled at edge e: alarm and escalate low after edge e.
- any_alarm/active_id same cycle as alarm; siren registered, same edge as first alarm.

## Structure
- Shared package alarm_pkg: channel FSM state enum, channel index constants (CH_FIRE=0, CH_BURGLAR=1, CH_RAIN=2).
- Sub-module alarm_channel (FSM, debounce and escalation counters), instantiated NUM_CH times by generate; alarm_hub holds priority encoder and siren.

## Test plan
- Reset then sensor=3'b001, arm=3'b111 held -> alarm=001 after 4th edge, any_alarm=1, active_id=0, siren 1,1,0,0,1...
- Sensor[1] high 3 cycles, low 1, high 4 -> alarm[1] only after the second 4-cycle run; glitch run produces nothing.
- Raise channels 2 then 1 -> active_id 2 then 1; ack[1] -> active_id 2; ack[2] -> any_alarm=0, siren=0.
- Alarm[0] held 16 cycles unacked -> escalate=001; ack[0] while sensor still high -> alarm=0, escalate=0, stays 0 until sensor drops and rises for 4 more cycles.
- arm=3'b011, sensor=3'b100 -> no alarm; disarm channel 0 while in ALARM -> alarm[0] stays 1.
- Reset asserted with two alarms and escalate active -> all outputs 0 next cycle; sensors held high re-raise after 4 cycles post-reset.
